// File: rtl/uart_sched_pkg.sv
// uart_sched_pkg: shared state encoding, default peripheral addresses and UART_CON bit positions
package uart_sched_pkg;
   typedef enum logic [1:0] {IDLE, SEND, GAP, POLL} state_t;
   localparam logic [31:0] TXD_ADDR_DEF = 32'h4000_0018;
   localparam logic [31:0] CON_ADDR_DEF = 32'h4000_0020;
   localparam int CON_SENDING = 4;
   localparam int CON_TXDONE  = 2;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: DEPTH x W synchronous FIFO with single-cycle flush and occupancy output
module sync_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [W-1:0]           din,
   output logic [W-1:0]           dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wp, r_rp;
   logic [AW:0]   r_level;
   logic          w_push, w_pop;
   assign full   = r_level == (AW+1)'(DEPTH);
   assign empty  = r_level == '0;
   assign level  = r_level;
   assign dout   = r_mem[r_rp];
   // a full FIFO refuses pushes even when a pop frees a slot in the same cycle
   assign w_push = push && !full && !flush;
   assign w_pop  = pop && !empty && !flush;
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp] <= din;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_level <= '0;
      end else if (flush) begin
         r_rp    <= r_wp;
         r_level <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + AW'(1);
         if (w_pop) r_rp <= r_rp + AW'(1);
         r_level <= r_level + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
      end
   end
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: bus master draining a byte FIFO into the UART, one TXD write then CON polls per byte
module uart_tx_sched
   import uart_sched_pkg::*;
#(
   parameter int          DEPTH    = 8,
   parameter logic [31:0] TXD_ADDR = TXD_ADDR_DEF,
   parameter logic [31:0] CON_ADDR = CON_ADDR_DEF,
   parameter int          POLL_GAP = 16,
   parameter logic [31:0] TIMEOUT  = 32'd40000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   input  logic [7:0]             in_data,
   output logic                   in_ready,
   input  logic                   flush,
   output logic                   bus_req,
   input  logic                   bus_gnt,
   output logic                   rd,
   output logic                   wr,
   output logic [31:0]            addr,
   output logic [31:0]            wdata,
   input  logic [31:0]            rdata,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] level,
   output logic                   err_timeout
);
   localparam int GW = $clog2(POLL_GAP + 1);
   state_t      r_state, w_next;
   logic [31:0] r_tmo;
   logic [GW-1:0] r_gap;
   logic        r_seen, r_err;
   logic [7:0]  w_head;
   logic        w_full, w_empty, w_rd, w_wr, w_timing, w_tmo_hit, w_unused;
   sync_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (in_valid),
      .pop   (w_wr),
      .flush (flush),
      .din   (in_data),
      .dout  (w_head),
      .full  (w_full),
      .empty (w_empty),
      .level (level)
   );
   assign w_timing  = r_state == GAP || r_state == POLL;
   assign w_tmo_hit = w_timing && r_tmo >= TIMEOUT;
   always_comb begin
      w_next = r_state;
      w_rd   = 1'b0;
      w_wr   = 1'b0;
      case (r_state)
         IDLE: w_next = w_empty ? IDLE : SEND;
         SEND: begin
            // a flush cancels a head byte that has not reached TXD yet
            w_wr   = bus_gnt && !flush && !w_empty;
            w_next = (flush || w_empty) ? IDLE : bus_gnt ? GAP : SEND;
         end
         GAP: w_next = (r_gap <= GW'(1)) ? POLL : GAP;
         POLL: begin
            w_rd   = bus_gnt && !w_tmo_hit;
            w_next = !bus_gnt ? POLL : (rdata[CON_SENDING] || !r_seen) ? GAP : IDLE;
         end
         default: w_next = IDLE;
      endcase
      if (w_tmo_hit) w_next = IDLE;
      if (reset) begin
         w_rd = 1'b0;
         w_wr = 1'b0;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_tmo   <= '0;
         r_gap   <= '0;
         r_seen  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_err   <= r_err | w_tmo_hit;
         if (w_wr) begin
            r_tmo  <= '0;
            r_seen <= 1'b0;
            r_gap  <= GW'(POLL_GAP);
         end else begin
            if (w_timing && r_tmo != '1) r_tmo <= r_tmo + 32'd1;
            if (r_state == GAP) r_gap <= r_gap - GW'(1);
            if (w_rd) begin
               r_gap  <= GW'(POLL_GAP);
               r_seen <= r_seen | rdata[CON_SENDING];
            end
         end
      end
   end
   assign rd          = w_rd;
   assign wr          = w_wr;
   assign bus_req     = r_state == SEND || r_state == POLL;
   assign addr        = w_wr ? TXD_ADDR : w_rd ? CON_ADDR : '0;
   assign wdata       = w_wr ? {24'd0, w_head} : '0;
   assign busy        = r_state != IDLE || !w_empty;
   assign in_ready    = !w_full;
   assign err_timeout = r_err;
   assign w_unused    = &{1'b0, rdata};
endmodule
